// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// 8 sets x 4 words (128-bit blocks). Hits complete with zero stall. Misses
// exchange whole blocks with L2 over a level-held request/ready handshake.
module l1_dcache (
  input  logic         clk,
  input  logic         reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         L2_read,
  output logic         L2_write,
  output logic [27:0]  L2_addr,
  output logic [127:0] L2_wdata,
  input  logic [127:0] L2_rdata,
  input  logic         L2_ready,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam logic [1:0] S_COMPARE   = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  // Controller state
  logic [1:0]   state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;
  logic         retry_q, retry_d;
  logic         l2_read_q, l2_read_d;
  logic         l2_write_q, l2_write_d;
  logic [27:0]  l2_addr_q, l2_addr_d;
  logic [127:0] l2_wdata_q, l2_wdata_d;
  logic [31:0]  hit_count_q, hit_count_d;
  logic [31:0]  miss_count_q, miss_count_d;

  // Tag and data storage; contents are meaningless until the valid bit is set
  logic [24:0]  tag_mem  [8];
  logic [127:0] data_mem [8];

  // Storage write port
  logic         mem_we;
  logic [24:0]  mem_tag_wdata;
  logic [127:0] mem_blk_wdata;

  // Request decode
  logic [2:0]   idx;
  logic [1:0]   off;
  logic [24:0]  req_tag;
  logic         req;
  logic [24:0]  cur_tag;
  logic [127:0] cur_blk;
  logic [127:0] merged_blk;
  logic [31:0]  blk_words [4];
  logic         hit;

  assign idx     = proc_addr[4:2];
  assign off     = proc_addr[1:0];
  assign req_tag = proc_addr[29:5];
  assign req     = proc_read | proc_write;
  assign cur_tag = tag_mem[idx];
  assign cur_blk = data_mem[idx];
  assign hit     = valid_q[idx] && (cur_tag == req_tag);

  // Split the indexed block into words and build the block with the
  // processor's write word merged in at the requested offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign blk_words[gi]            = cur_blk[gi*32 +: 32];
      assign merged_blk[gi*32 +: 32]  = (off == 2'(gi)) ? proc_wdata : cur_blk[gi*32 +: 32];
    end
  endgenerate

  // Next-state, handshake and storage-write decisions
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    retry_d       = retry_q;
    l2_read_d     = l2_read_q;
    l2_write_d    = l2_write_q;
    l2_addr_d     = l2_addr_q;
    l2_wdata_d    = l2_wdata_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    mem_we        = 1'b0;
    mem_tag_wdata = req_tag;
    mem_blk_wdata = merged_blk;
    proc_stall    = 1'b0;

    case (state_q)
      S_COMPARE: begin
        if (req) begin
          if (hit) begin
            // A write (or read+write) updates the word in place
            if (proc_write) begin
              mem_we        = 1'b1;
              mem_tag_wdata = cur_tag;
              mem_blk_wdata = merged_blk;
              dirty_d[idx]  = 1'b1;
            end
            // Only first-lookup hits count; a retry after a fill does not
            if (!retry_q) begin
              hit_count_d = hit_count_q + 32'd1;
            end
            retry_d = 1'b0;
          end else begin
            proc_stall   = 1'b1;
            miss_count_d = miss_count_q + 32'd1;
            retry_d      = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d    = S_WRITEBACK;
              l2_write_d = 1'b1;
              l2_addr_d  = {cur_tag, idx};
              l2_wdata_d = cur_blk;
            end else begin
              state_d   = S_ALLOCATE;
              l2_read_d = 1'b1;
              l2_addr_d = proc_addr[29:2];
            end
          end
        end
      end

      S_WRITEBACK: begin
        proc_stall = 1'b1;
        if (l2_write_q && L2_ready) begin
          l2_write_d = 1'b0;
          l2_read_d  = 1'b1;
          l2_addr_d  = proc_addr[29:2];
          state_d    = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        proc_stall = 1'b1;
        if (l2_read_q && L2_ready) begin
          mem_we        = 1'b1;
          mem_tag_wdata = req_tag;
          mem_blk_wdata = L2_rdata;
          valid_d[idx]  = 1'b1;
          dirty_d[idx]  = 1'b0;
          l2_read_d     = 1'b0;
          state_d       = S_COMPARE;
        end
      end

      default: begin
        state_d    = S_COMPARE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  // Read word is driven only for a pure read that hits in COMPARE
  always_comb begin
    proc_rdata = 32'd0;
    if ((state_q == S_COMPARE) && proc_read && !proc_write && hit) begin
      proc_rdata = blk_words[off];
    end
  end

  // Controller registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_COMPARE;
      valid_q      <= 8'd0;
      dirty_q      <= 8'd0;
      retry_q      <= 1'b0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= 28'd0;
      l2_wdata_q   <= 128'd0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      retry_q      <= retry_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data storage write; arrays are not reset, validity lives in valid_q
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      tag_mem[idx]  <= mem_tag_wdata;
      data_mem[idx] <= mem_blk_wdata;
    end
  end

  assign L2_read    = l2_read_q;
  assign L2_write   = l2_write_q;
  assign L2_addr    = l2_addr_q;
  assign L2_wdata   = l2_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed plus randomized accesses checked against a
// behavioural cache/L2 model held in arrays.
module tb_l1_dcache;

  logic         clk;
  logic         reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         L2_read;
  logic         L2_write;
  logic [27:0]  L2_addr;
  logic [127:0] L2_wdata;
  logic [127:0] L2_rdata;
  logic         L2_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  l1_dcache dut (
    .clk        (clk),
    .reset      (reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .L2_read    (L2_read),
    .L2_write   (L2_write),
    .L2_addr    (L2_addr),
    .L2_wdata   (L2_wdata),
    .L2_rdata   (L2_rdata),
    .L2_ready   (L2_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cache contents per set plus a backing L2 memory
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] l2mem [logic [27:0]];
  logic [31:0]  exp_hit;
  logic [31:0]  exp_miss;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Untouched L2 blocks hold a pattern derived from their block address
  function automatic logic [127:0] l2_get(input logic [27:0] ba);
    logic [127:0] r;
    if (l2mem.exists(ba)) return l2mem[ba];
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {2'(w), 2'b10, ba};
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = 25'd0;
      m_data[s]  = 128'd0;
    end
    exp_hit  = 32'd0;
    exp_miss = 32'd0;
  endtask

  // Wait dly cycles for one L2 transfer; ready is given in the last one
  task automatic wait_xfer(input int dly);
    for (int c = 1; c <= dly; c++) begin
      chk("xfer_stall", 128'(proc_stall), 128'(1'b1));
      chk("xfer_excl", 128'(L2_read & L2_write), 128'(1'b0));
      if (c == dly) L2_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      L2_ready = 1'b0;
    end
  endtask

  // One processor access (kind 0 read, 1 write, 2 read+write); starts and ends at a negedge
  task automatic do_access(input int kind, input logic [29:0] a, input logic [31:0] wd, input int dly);
    logic [2:0]  idx;
    logic [24:0] tg;
    int          off;
    logic        wr;
    logic        m_hit;
    idx   = a[4:2];
    tg    = a[29:5];
    off   = int'(a[1:0]);
    wr    = (kind != 0);
    m_hit = m_valid[idx] && (m_tag[idx] == tg);
    proc_read  = (kind != 1);
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    if (m_hit) begin
      L2_ready = 1'($urandom_range(0, 1));
      #1;
      chk("hit_stall", 128'(proc_stall), 128'(1'b0));
      if (kind == 0) chk("hit_rdata", 128'(proc_rdata), 128'(m_data[idx][off*32 +: 32]));
      @(posedge clk);
      @(negedge clk);
      L2_ready = 1'b0;
      chk("hit_l2_idle", 128'({L2_read, L2_write}), 128'(2'b00));
      if (wr) begin
        m_data[idx][off*32 +: 32] = wd;
        m_dirty[idx] = 1'b1;
      end
      exp_hit = exp_hit + 32'd1;
    end else begin
      #1;
      chk("miss_stall", 128'(proc_stall), 128'(1'b1));
      @(posedge clk);
      @(negedge clk);
      exp_miss = exp_miss + 32'd1;
      chk("miss_count_now", 128'(miss_count), 128'(exp_miss));
      if (m_valid[idx] && m_dirty[idx]) begin
        chk("wb_req", 128'({L2_read, L2_write}), 128'(2'b01));
        chk("wb_addr", 128'(L2_addr), 128'({m_tag[idx], idx}));
        chk("wb_data", L2_wdata, m_data[idx]);
        l2mem[{m_tag[idx], idx}] = m_data[idx];
        wait_xfer(dly);
      end
      chk("fill_req", 128'({L2_read, L2_write}), 128'(2'b10));
      chk("fill_addr", 128'(L2_addr), 128'(a[29:2]));
      L2_rdata = l2_get(a[29:2]);
      wait_xfer(dly);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = l2_get(a[29:2]);
      chk("retry_stall", 128'(proc_stall), 128'(1'b0));
      chk("retry_l2_idle", 128'({L2_read, L2_write}), 128'(2'b00));
      if (kind == 0) chk("retry_rdata", 128'(proc_rdata), 128'(m_data[idx][off*32 +: 32]));
      if (wr) begin
        m_data[idx][off*32 +: 32] = wd;
        m_dirty[idx] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    proc_read  = 1'b0;
    proc_write = 1'b0;
    chk("hit_count", 128'(hit_count), 128'(exp_hit));
    chk("miss_count", 128'(miss_count), 128'(exp_miss));
    $display("access kind=%0d addr=%08h wdata=%08h hit=%0d hits=%0d misses=%0d",
             kind, a, wd, m_hit, hit_count, miss_count);
  endtask

  initial begin
    logic [29:0] ra;
    logic [29:0] wb_a;
    logic [29:0] wb_b;
    reset      = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'd0;
    proc_wdata = 32'd0;
    L2_rdata   = 128'd0;
    L2_ready   = 1'b0;
    model_reset();
    l2mem[28'h1] = {32'hD, 32'hC, 32'hB, 32'hA};

    // Reset and check the idle outputs
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", 128'(proc_stall), 128'(1'b0));
    chk("rst_rdata", 128'(proc_rdata), 128'(0));
    chk("rst_l2req", 128'({L2_read, L2_write}), 128'(2'b00));
    chk("rst_l2addr", 128'(L2_addr), 128'(0));
    chk("rst_l2wdata", L2_wdata, 128'(0));
    chk("rst_hits", 128'(hit_count), 128'(0));
    chk("rst_misses", 128'(miss_count), 128'(0));
    @(negedge clk);

    // Cold miss with a 3-cycle L2, then a hit on the neighbouring word
    do_access(0, 30'h4, 32'h0, 3);
    do_access(0, 30'h5, 32'h0, 1);
    chk("plan_hit1", 128'(hit_count), 128'(1));
    // Write hit, read back, then dirty conflict miss and clean conflict miss
    do_access(1, 30'h6, 32'h1234, 1);
    do_access(0, 30'h6, 32'h0, 1);
    do_access(0, 30'h24, 32'h0, 2);
    do_access(0, 30'h4, 32'h0, 2);
    do_access(0, 30'h6, 32'h0, 1);

    // L2_ready held high while idle must do nothing
    L2_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_rdy_stall", 128'(proc_stall), 128'(1'b0));
      chk("idle_rdy_l2", 128'({L2_read, L2_write}), 128'(2'b00));
      chk("idle_rdy_miss", 128'(miss_count), 128'(exp_miss));
    end
    L2_ready = 1'b0;

    // Long ALLOCATE: ready withheld for 10 cycles
    do_access(0, {25'd100, 3'd5, 2'd2}, 32'h0, 11);

    // Randomized mix over a few tags per set to force conflicts
    for (int n = 0; n < 150; n++) begin
      ra = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_access(int'($urandom_range(0, 2)), ra, $urandom, int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a write-back: dirty data is lost
    wb_a = {25'd200, 3'd3, 2'd0};
    wb_b = {25'd201, 3'd3, 2'd1};
    do_access(1, wb_a, 32'hCAFE_F00D, 1);
    proc_read = 1'b1;
    proc_addr = wb_b;
    #1;
    chk("mwb_stall", 128'(proc_stall), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    chk("mwb_write", 128'({L2_read, L2_write}), 128'(2'b01));
    reset     = 1'b1;
    proc_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("mwb_l2req", 128'({L2_read, L2_write}), 128'(2'b00));
    chk("mwb_stall0", 128'(proc_stall), 128'(1'b0));
    chk("mwb_hits", 128'(hit_count), 128'(0));
    chk("mwb_misses", 128'(miss_count), 128'(0));
    do_access(0, wb_b, 32'h0, 2);
    do_access(0, wb_a, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
